menu_controller: RTL

- Top-level sequencer for the board menu.
- Debounces the raw btnL/btnR/btnC pushbuttons and moves a cursor over the task items (MENU_OLED_A, MENU_OLED_B, MENU_AVI).
- Enters the selected task, then returns to the menu on a long press of btnC.
- Drives the 4-bit state bus consumed by the menu display logic and the task blocks, and forwards gated button pulses to the active task.

---
 rtl/menu_controller_pkg.sv | 31 +++
 rtl/button_debounce.sv | 59 +++++
 rtl/menu_controller.sv | 111 +++++++++++
 3 files changed

// File: rtl/menu_controller_pkg.sv
// Shared definitions for the board menu: item codes, sequencer states,
// default timing constants and the cursor wrap helper.
package menu_controller_pkg;

    typedef enum logic [3:0] {
        MENU_INACTIVE = 4'd0,
        MENU_OLED_A   = 4'd1,
        MENU_OLED_B   = 4'd2,
        MENU_AVI      = 4'd3
    } menuItem_t;

    typedef enum logic {
        BROWSE = 1'b0,
        ACTIVE = 1'b1
    } menuState_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES   = 100000;
    localparam int DEFAULT_LONG_PRESS_CYCLES = 100000000;
    localparam int DEFAULT_NUM_ITEMS         = 3;

    // Item codes run 1..lastItem; stepping off either end wraps to the other.
    function automatic logic [3:0] stepItem(input logic [3:0] item,
                                            input logic       up,
                                            input logic [3:0] lastItem);
        if (up) begin
            return (item == lastItem) ? MENU_OLED_A : item + 4'd1;
        end
        return (item == MENU_OLED_A) ? lastItem : item - 4'd1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes, debounces and edge-detects one raw pushbutton.
// A button already held when reset releases is ignored until it is let go once.
module button_debounce
    import menu_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic level,
    output logic press_pulse
);

    localparam int CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic            syncA;
    logic            syncB;
    logic [1:0]      syncFill;
    logic            levelPrev;
    logic            released;
    logic [CntW-1:0] stableCnt;

    // syncFill marks when syncB holds a real sample rather than its reset value,
    // so a button held through reset is not mistaken for a release.
    always_ff @(posedge CLK) begin
        if (RST) begin
            syncA       <= 1'b0;
            syncB       <= 1'b0;
            syncFill    <= 2'b00;
            released    <= 1'b0;
            stableCnt   <= '0;
            level       <= 1'b0;
            levelPrev   <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            syncA    <= raw;
            syncB    <= syncA;
            syncFill <= {syncFill[0], 1'b1};

            if (syncFill[1] && !syncB) begin
                released <= 1'b1;
            end

            if (syncB == level) begin
                stableCnt <= '0;
            end else if (stableCnt == CntW'(DEBOUNCE_CYCLES)) begin
                level     <= syncB;
                stableCnt <= '0;
            end else begin
                stableCnt <= stableCnt + CntW'(1);
            end

            levelPrev   <= level;
            press_pulse <= level && !levelPrev && released;
        end
    end

endmodule

// File: rtl/menu_controller.sv
// Board menu sequencer: cursor navigation while browsing, task entry on btnC,
// button forwarding to the active task and long-press exit back to the menu.
module menu_controller
    import menu_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
    parameter int NUM_ITEMS         = DEFAULT_NUM_ITEMS
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       btnC,
    output logic [3:0] state,
    output logic [3:0] cursor,
    output logic [2:0] task_btn
);

    localparam int         LpW      = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [3:0] LastItem = 4'(NUM_ITEMS);

    menuState_t     fsmState;
    menuState_t     fsmNext;
    logic [3:0]     stateNext;
    logic [3:0]     cursorNext;
    logic [2:0]     taskBtnNext;
    logic           arm;
    logic           armNext;
    logic [LpW-1:0] lpCnt;
    logic [LpW-1:0] lpNext;

    logic pulseL;
    logic pulseR;
    logic pulseC;
    logic levelC;
    logic unusedLevelL;
    logic unusedLevelR;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) debounceL (
        .CLK(CLK), .RST(RST), .raw(btnL), .level(unusedLevelL), .press_pulse(pulseL)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) debounceR (
        .CLK(CLK), .RST(RST), .raw(btnR), .level(unusedLevelR), .press_pulse(pulseR)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) debounceC (
        .CLK(CLK), .RST(RST), .raw(btnC), .level(levelC), .press_pulse(pulseC)
    );

    // arm stays low until btnC is seen released, so the press that entered a
    // task can neither be forwarded as C nor count towards the long-press exit.
    always_comb begin
        fsmNext     = fsmState;
        stateNext   = state;
        cursorNext  = cursor;
        taskBtnNext = 3'b000;
        armNext     = arm;
        lpNext      = lpCnt;

        unique case (fsmState)
            BROWSE: begin
                lpNext = '0;
                if (pulseC) begin
                    fsmNext   = ACTIVE;
                    stateNext = cursor;
                    armNext   = 1'b0;
                end else if (pulseL && !pulseR) begin
                    cursorNext = stepItem(cursor, 1'b0, LastItem);
                end else if (pulseR && !pulseL) begin
                    cursorNext = stepItem(cursor, 1'b1, LastItem);
                end
            end
            ACTIVE: begin
                taskBtnNext = {pulseC && arm, pulseR, pulseL};
                if (!levelC) begin
                    armNext = 1'b1;
                    lpNext  = '0;
                end else if (arm) begin
                    if (lpCnt == LpW'(LONG_PRESS_CYCLES - 1)) begin
                        fsmNext   = BROWSE;
                        stateNext = MENU_INACTIVE;
                        lpNext    = '0;
                    end else begin
                        lpNext = lpCnt + LpW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fsmState <= BROWSE;
            state    <= MENU_INACTIVE;
            cursor   <= MENU_OLED_A;
            task_btn <= 3'b000;
            arm      <= 1'b0;
            lpCnt    <= '0;
        end else begin
            fsmState <= fsmNext;
            state    <= stateNext;
            cursor   <= cursorNext;
            task_btn <= taskBtnNext;
            arm      <= armNext;
            lpCnt    <= lpNext;
        end
    end

endmodule
